// File: rtl/position_shifter.sv
// position_shifter: one-hot position register stepped one slot per button press, with a padded display bus.
// Defining AUTO_REPEAT_EN adds hold-to-repeat stepping (REPEAT_DELAY, REPEAT_PERIOD).
module position_shifter #(
  parameter int WIDTH = 4,
  parameter int PAD = 3,
  parameter int WRAP = 0,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_PERIOD = 4,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_left,
  input  logic                 shift_right,
  input  logic                 load,
  input  logic [IW-1:0]        load_pos,
  input  logic                 fast,
  output logic [WIDTH-1:0]     state,
  output logic [IW-1:0]        pos,
  output logic                 at_left,
  output logic                 at_right,
  output logic [WIDTH+PAD-1:0] out
);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB = WIDTH'(1);
  logic idle_l, idle_r, rise_l, rise_r, rep_l, rep_r, mv_l, mv_r;
  logic [WIDTH-1:0] nxt, rev;
  // idle_* records "input was low last cycle", so a button held through reset never counts as a press
  assign rise_l = shift_left & idle_l;
  assign rise_r = shift_right & idle_r;
`ifdef AUTO_REPEAT_EN
  localparam int MX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = $clog2(MX + 1);
  logic [CW-1:0] cnt;
  logic armed, started, one, acc, rep;
  assign one = shift_left ^ shift_right;
  assign acc = ~load & (rise_l ^ rise_r);
  assign rep = armed & one & (cnt == (started ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1)));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      armed <= 1'b0;
      started <= 1'b0;
    end else if (load | ~one | acc) begin
      cnt <= '0;
      started <= 1'b0;
      armed <= acc;
    end else if (rep) begin
      cnt <= '0;
      started <= 1'b1;
    end else if (armed && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  assign rep_l = rep & shift_left;
  assign rep_r = rep & shift_right;
`else
  assign rep_l = 1'b0;
  assign rep_r = 1'b0;
`endif
  assign mv_l = (rise_l | rep_l) & ~(rise_l & rise_r);
  assign mv_r = (rise_r | rep_r) & ~(rise_l & rise_r);
  assign nxt = load ? ((int'(load_pos) < WIDTH) ? LSB << load_pos : state) :
               mv_l ? (state[WIDTH-1] ? (WRAP != 0 ? LSB : state) : state << 1) :
               mv_r ? (state[0] ? (WRAP != 0 ? MSB : state) : state >> 1) : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= MSB;
      idle_l <= 1'b0;
      idle_r <= 1'b0;
    end else begin
      state <= nxt;
      idle_l <= ~shift_left;
      idle_r <= ~shift_right;
    end
  always_comb begin
    pos = '0;
    rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (state[i]) pos = IW'(i);
      rev[i] = state[WIDTH-1-i];
    end
  end
  assign at_left = state[WIDTH-1];
  assign at_right = state[0];
  assign out = fast ? {{PAD{1'b0}}, state} : {rev, {PAD{1'b0}}};
endmodule
